// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial shifter.
package serial_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

    // Width of the SCLK edge counter: enough to index 2*width edges.
    function automatic int unsigned edge_cnt_w(input int unsigned width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/serial_shifter_tick_gen.sv
// Half-period tick generator: one-cycle tick every div_in+1 cycles,
// restarted from zero while restart_in is high.
module tick_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             restart_in,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_out
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Tick on terminal count; equality compare means div_in at max never wraps early.
    always_comb begin
        tick_out = (cnt_q == div_in);
        cnt_d    = cnt_q + DIV_W'(1);
        if (restart_in || tick_out) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// SPI-style serial shifter: one WIDTH-bit full-duplex transfer per start,
// configurable clock divider, CPOL/CPHA and bit order.
module serial_shifter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [DIV_W-1:0] div_in,
    input  logic             cpol_in,
    input  logic             cpha_in,
    input  logic             lsb_first_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WIDTH-1:0] data_out,
    output logic             sclk_out,
    output logic             mosi_out,
    input  logic             miso_in,
    output logic             cs_n_out
);

    localparam int unsigned EDGE_W = edge_cnt_w(WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH - 1);

    state_e            state_q, state_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;

    logic tick;
    logic tick_restart;
    logic lead_edge;
    logic last_edge;
    logic sample_en;
    logic shift_en;

    assign tick_restart = (state_q == ST_IDLE);

    tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .restart_in(tick_restart),
        .div_in    (div_q),
        .tick_out  (tick)
    );

    // Next-state logic: sequencing, SCLK edges, shift/sample control.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        lead_edge = ~edge_q[0];
        last_edge = (edge_q == LAST_EDGE);

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_LEAD;
                    div_d   = div_in;
                    cpol_d  = cpol_in;
                    cpha_d  = cpha_in;
                    lsb_d   = lsb_first_in;
                    sclk_d  = cpol_in;
                    edge_d  = '0;
                    rx_d    = '0;
                    // CPHA=0 must have the first bit valid before the first leading edge.
                    if (cpha_in) begin
                        tx_d = data_in;
                    end else begin
                        mosi_d = lsb_first_in ? data_in[0] : data_in[WIDTH-1];
                        tx_d   = lsb_first_in ? (data_in >> 1) : (data_in << 1);
                    end
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d    = ~sclk_q;
                    edge_d    = edge_q + EDGE_W'(1);
                    sample_en = cpha_q ? ~lead_edge : lead_edge;
                    shift_en  = cpha_q ? lead_edge : (~lead_edge & ~last_edge);
                    if (last_edge) begin
                        state_d = ST_TRAIL;
                        edge_d  = '0;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    data_d  = rx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sample_en) begin
            rx_d = lsb_q ? {miso_in, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso_in};
        end
        if (shift_en) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[WIDTH-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            edge_q  <= '0;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    assign ready_out = (state_q == ST_IDLE);
    assign cs_n_out  = (state_q == ST_IDLE);
    assign done_out  = done_q;
    assign data_out  = data_q;
    assign sclk_out  = sclk_q;
    assign mosi_out  = mosi_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: table of transfers against an
// independent SPI slave model, plus back-to-back and mid-transfer reset.
module tb_serial_shifter;

    localparam int unsigned W     = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned LIMIT = 6000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] div;
    logic          cpol, cpha, lsb_first;
    logic [W-1:0]  data_i;
    logic          start;
    logic          ready, done;
    logic [W-1:0]  data_o;
    logic          sclk, mosi, miso, cs_n;
    logic          miso_slave;
    logic          loop_en;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_slave;

    serial_shifter #(
        .WIDTH(W),
        .DIV_W(DW)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .div_in      (div),
        .cpol_in     (cpol),
        .cpha_in     (cpha),
        .lsb_first_in(lsb_first),
        .data_in     (data_i),
        .start_in    (start),
        .ready_out   (ready),
        .done_out    (done),
        .data_out    (data_o),
        .sclk_out    (sclk),
        .mosi_out    (mosi),
        .miso_in     (miso),
        .cs_n_out    (cs_n)
    );

    typedef struct {
        logic [DW-1:0] div;
        logic          cpol;
        logic          cpha;
        logic          lsb;
        logic          loopb;
        logic [W-1:0]  data;
        logic [W-1:0]  slave_word;
        logic [W-1:0]  exp_rx;
        logic [W-1:0]  exp_mosi;
        int unsigned   exp_cs;
    } vec_t;

    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic slave_bit(input vec_t v, input int unsigned k);
        logic [W-1:0] w;
        w = v.slave_word;
        return v.lsb ? w[k] : w[W-1-k];
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int unsigned cyc, cs_low, edges, gap, bad, sk, rn, extra;
        logic        prev_sclk, done_seen, leading, stable;
        logic [W-1:0] slave_rx, held_data;
        logic        held_mosi;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        div = v.div; cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
        data_i = v.data; loop_en = v.loopb; miso_slave = 1'b0; start = 1'b1;
        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b0;
        // changes after acceptance must have no effect
        data_i = ~v.data; div = v.div ^ 8'h05; cpol = ~v.cpol; cpha = ~v.cpha; lsb_first = ~v.lsb;
        check({tag, "_sclk_lead"}, 32'(sclk), 32'(v.cpol));
        cs_low = 0; edges = 0; gap = 0; bad = 0; rn = 0; slave_rx = '0;
        prev_sclk = sclk; done_seen = 1'b0;
        if (!v.cpha) begin
            miso_slave = slave_bit(v, 0);
            sk = 1;
        end else begin
            sk = 0;
        end
        cyc = 0;
        while (cyc < LIMIT && !done_seen) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 5) start = 1'b1;
            if (cyc == 6) start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                check({tag, "_cs_at_done"}, 32'(cs_n), 32'd1);
                check({tag, "_ready_at_done"}, 32'(ready), 32'd1);
            end else begin
                if (!cs_n) cs_low++;
                if (sclk != prev_sclk) begin
                    edges++;
                    if (edges > 1 && gap != 32'(v.div) + 1) bad++;
                    gap = 0;
                    leading = (sclk != v.cpol);
                    if (leading != v.cpha) begin
                        if (rn < W) begin
                            if (v.lsb) slave_rx[rn] = mosi;
                            else       slave_rx[W-1-rn] = mosi;
                            rn++;
                        end
                    end else if (sk < W) begin
                        miso_slave = slave_bit(v, sk);
                        sk++;
                    end
                end
                gap++;
                prev_sclk = sclk;
            end
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_data_out"}, 32'(data_o), 32'(v.exp_rx));
        check({tag, "_mosi_word"}, 32'(slave_rx), 32'(v.exp_mosi));
        check({tag, "_cs_low"}, cs_low, v.exp_cs);
        check({tag, "_sclk_edges"}, edges, 2 * W);
        check({tag, "_bad_halfper"}, bad, 32'd0);
        check({tag, "_sclk_after"}, 32'(sclk), 32'(v.cpol));
        held_data = data_o; held_mosi = mosi; extra = 0; stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
            if (data_o !== held_data || mosi !== held_mosi || sclk !== v.cpol) stable = 1'b0;
        end
        check({tag, "_extra_done"}, extra, 32'd0);
        check({tag, "_idle_stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        int unsigned n, hi, edges;
        logic        seen, prev_sclk;

        vecs[0] = '{div: 8'd1,   cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, loopb: 1'b1, data: 8'hA5,
                    slave_word: 8'h00, exp_rx: 8'hA5, exp_mosi: 8'hA5, exp_cs: 36};
        vecs[1] = '{div: 8'd1,   cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, loopb: 1'b0, data: 8'h3C,
                    slave_word: 8'hC3, exp_rx: 8'hC3, exp_mosi: 8'h3C, exp_cs: 36};
        vecs[2] = '{div: 8'd1,   cpol: 1'b0, cpha: 1'b1, lsb: 1'b0, loopb: 1'b0, data: 8'h3C,
                    slave_word: 8'h96, exp_rx: 8'h96, exp_mosi: 8'h3C, exp_cs: 36};
        vecs[3] = '{div: 8'd2,   cpol: 1'b1, cpha: 1'b0, lsb: 1'b0, loopb: 1'b0, data: 8'h3C,
                    slave_word: 8'h5A, exp_rx: 8'h5A, exp_mosi: 8'h3C, exp_cs: 54};
        vecs[4] = '{div: 8'd2,   cpol: 1'b1, cpha: 1'b1, lsb: 1'b0, loopb: 1'b0, data: 8'h3C,
                    slave_word: 8'h0F, exp_rx: 8'h0F, exp_mosi: 8'h3C, exp_cs: 54};
        vecs[5] = '{div: 8'd0,   cpol: 1'b0, cpha: 1'b0, lsb: 1'b1, loopb: 1'b0, data: 8'h3C,
                    slave_word: 8'h01, exp_rx: 8'h01, exp_mosi: 8'h3C, exp_cs: 18};
        vecs[6] = '{div: 8'd3,   cpol: 1'b1, cpha: 1'b1, lsb: 1'b1, loopb: 1'b0, data: 8'h81,
                    slave_word: 8'h80, exp_rx: 8'h80, exp_mosi: 8'h81, exp_cs: 72};
        vecs[7] = '{div: 8'd255, cpol: 1'b0, cpha: 1'b1, lsb: 1'b0, loopb: 1'b0, data: 8'h12,
                    slave_word: 8'h34, exp_rx: 8'h34, exp_mosi: 8'h12, exp_cs: 4608};

        // Reset with start asserted: reset must win.
        rst_n = 1'b0; start = 1'b1; div = '0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        data_i = 8'hFF; loop_en = 1'b0; miso_slave = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back: start held high across the done cycle.
        div = 8'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; data_i = 8'h5A;
        loop_en = 1'b1; start = 1'b1;
        n = 0; seen = 1'b0;
        while (n < LIMIT && !seen) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check("b2b_first_done", 32'(seen), 32'd1);
        check("b2b_first_data", 32'(data_o), 32'h5A);
        check("b2b_ready_at_done", 32'(ready), 32'd1);
        hi = 1; n = 0;
        @(negedge clk);
        while (cs_n && n < LIMIT) begin
            hi++; n++;
            @(negedge clk);
        end
        check("b2b_cs_high", hi, 32'd1);
        start = 1'b0;
        n = 0; seen = 1'b0;
        while (n < LIMIT && !seen) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check("b2b_second_done", 32'(seen), 32'd1);
        check("b2b_second_data", 32'(data_o), 32'h5A);

        // Reset in the middle of XFER.
        @(negedge clk);
        div = 8'd1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; data_i = 8'hFF;
        loop_en = 1'b0; miso_slave = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0; n = 0; prev_sclk = sclk;
        while (edges < 5 && n < LIMIT) begin
            @(negedge clk);
            if (sclk != prev_sclk) edges++;
            prev_sclk = sclk;
            n++;
        end
        check("mid_edges_reached", edges, 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_cs_n", 32'(cs_n), 32'd1);
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_sclk", 32'(sclk), 32'd0);
        check("mid_data", 32'(data_o), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) hi++;
        end
        check("mid_no_done", hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
